modmul_pipe_2423: RTL and testbench
===================================

MODMUL_PIPE_2423 -- requirements
Module: modmul_pipe_2423

Interface
REQ-001 SHALL have parameter Q, default 2423, the modulus.
REQ-002 SHALL have parameter MU, default 6924 (floor(2^24/Q)), the Barrett constant.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operand pair offered.
REQ-006 SHALL have port in_ready, output, 1, operand pair accepted when in_valid & in_ready.
REQ-007 SHALL have port in_a, input, 12, operand A (legal range 0..Q-1).
REQ-008 SHALL have port in_b, input, 12, operand B (legal range 0..Q-1).
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer takes result when out_valid & out_ready.
REQ-011 SHALL have port out_r, output, 12, (in_a*in_b) mod Q.
REQ-012 SHALL have port out_err, output, 1, operand-range flag, qualified by out_valid.

Function
REQ-013 SHALL be a 3-stage pipeline with per-stage valid bits: S1 registers the 23-bit product; S2 registers product and t; S3 registers the corrected result.
REQ-014 SHALL have a pipeline enable: en = !out_valid | out_ready; in_ready = en; every stage advances only when en=1.
REQ-015 SHALL have a fixed latency of 3 en-cycles from acceptance to out_valid; throughput one result per cycle while out_ready=1.
REQ-016 SHALL compute in S1 p = in_a*in_b at a full 23 bits, with no truncation.
REQ-017 SHALL compute in S2 q = p>>12 (11 bits), qh = q*MU at 24 bits (not 23), and t = qh>>12 (12 bits).
REQ-018 SHALL compute in S3 r = p - t*Q at 23 bits, followed by one conditional subtraction: out_r = (r >= Q) ? r-Q : r.
REQ-019 SHALL hold out_r and out_valid stable while out_valid=1 and out_ready=0, with no data loss or duplication.
REQ-020 SHALL let bubbles (in_valid=0) propagate as invalid stages; S3 valid updates only when en=1.
REQ-021 SHALL allow simultaneous output consume and input accept in one cycle.
REQ-022 SHALL carry out_err through the pipeline alongside its data.

Reset
REQ-023 SHALL clear all stage valid bits on rst; out_valid=0, out_r=0, out_err=0.
REQ-024 SHALL discard all in-flight data when rst is asserted mid-operation; no result emerges afterward.
REQ-025 SHALL hold in_ready=1 during and after reset (en=1 because out_valid=0).

Configuration
REQ-026 SHALL use macro MODMUL2423_RANGE_CHECK_EN: when defined, S1 sets err = (in_a >= Q) | (in_b >= Q), and the product is still computed and reduced.
REQ-027 SHALL, when MODMUL2423_RANGE_CHECK_EN is undefined, keep out_err present and tie it to 0; no compare logic.

Structure
REQ-028 SHALL place Q, MU, and the widths (12 operand, 23 product, 24 qh) in a shared package, modq_pkg.
REQ-029 SHALL use one sub-module, barrett_stage_2423, holding S2/S3 reduction registers with a valid/enable interface.

Verification
REQ-030 SHALL cover: a=2422,b=2422 -> p=5866084, out_r=1 exactly 3 cycles after acceptance (exercises the 24-bit qh path and the correction).
REQ-031 SHALL cover: a=1000,b=3 -> out_r=577; a=1234,b=2 -> out_r=45; a=0,b=2422 -> out_r=0.
REQ-032 SHALL cover: a 10-beat back-to-back stream with out_ready low for 4 cycles mid-stream -> in_ready low during the stall, all 10 results in order, none lost or duplicated.
REQ-033 SHALL cover: rst asserted for 1 cycle while 3 items are in flight -> out_valid=0 next cycle, no stale results, new input accepted immediately.
REQ-034 SHALL cover: exhaustive sweep of all a,b in 0..2422 versus a reference model -> out_r == a*b mod 2423 for every pair.
REQ-035 SHALL cover: with MODMUL2423_RANGE_CHECK_EN, a=2423,b=1 -> out_err=1; a=2422,b=1 -> out_err=0; without the macro, out_err=0 always.

Source files
------------

// File: rtl/modq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modq_pkg
// Description : Shared constants and datapath types for the mod-2423
//               Barrett multiplier: modulus, Barrett constant and the
//               operand / product / quotient-estimate widths.
// Revision    : 1.0 - initial release
// ============================================================================
package modq_pkg;

    // Modulus and Barrett constant floor(2^24 / Q)
    localparam int unsigned C_Q_DEFAULT  = 2423;
    localparam int unsigned C_MU_DEFAULT = 6924;

    // Datapath widths
    localparam int unsigned C_OP_W   = 12;  // operands and result
    localparam int unsigned C_PROD_W = 23;  // full a*b for legal operands
    localparam int unsigned C_QUO_W  = 11;  // p >> 12
    localparam int unsigned C_QH_W   = 24;  // q*MU overflows 23 bits
    localparam int unsigned C_T_W    = 12;  // quotient estimate
    localparam int unsigned C_SHIFT  = 12;

    typedef logic [C_OP_W-1:0]   operand_t;
    typedef logic [C_PROD_W-1:0] prod_t;
    typedef logic [C_QUO_W-1:0]  quo_t;
    typedef logic [C_QH_W-1:0]   qh_t;
    typedef logic [C_T_W-1:0]    t_t;

endpackage : modq_pkg
`default_nettype wire

// File: rtl/barrett_stage_2423.sv
`default_nettype none
// ============================================================================
// Module      : barrett_stage_2423
// Description : Reduction half of the mod-2423 multiplier. Stage S2 forms
//               the Barrett quotient estimate t from the product p; stage
//               S3 forms r = p - t*Q and the final correction into 0..Q-1.
//               Both stages advance only while en is high.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset, clears all stages
//               en        - pipeline advance enable
//               in_valid  - S1 valid bit feeding S2
//               in_p      - S1 product (23 bit)
//               in_err    - S1 operand-range flag
//               out_valid - S3 valid bit
//               out_r     - reduced result (12 bit)
//               out_err   - range flag travelling with out_r
// Revision    : 1.0 - initial release
// ============================================================================
module barrett_stage_2423
    import modq_pkg::*;
#(
    parameter int unsigned Q  = C_Q_DEFAULT,
    parameter int unsigned MU = C_MU_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  prod_t       in_p,
    input  logic        in_err,
    output logic        out_valid,
    output operand_t    out_r,
    output logic        out_err
);

    localparam prod_t C_Q_P   = prod_t'(Q);
    localparam prod_t C_Q2_P  = prod_t'(2 * Q);
    localparam qh_t   C_MU_QH = qh_t'(MU);

    // S2 registers
    logic     s2_valid_q, s2_valid_d;
    prod_t    s2_p_q,     s2_p_d;
    t_t       s2_t_q,     s2_t_d;
    logic     s2_err_q,   s2_err_d;

    // S3 registers
    logic     s3_valid_q, s3_valid_d;
    operand_t s3_r_q,     s3_r_d;
    logic     s3_err_q,   s3_err_d;

    // Combinational datapath
    quo_t     w_quo;
    qh_t      w_qh;
    t_t       w_t;
    prod_t    w_r;
    operand_t w_r_sub1;
    operand_t w_r_sub2;
    operand_t w_res;

    // ------------------------------------------------------------------
    // S2: quotient estimate t = ((p >> 12) * MU) >> 12
    // ------------------------------------------------------------------
    always_comb begin
        w_quo = quo_t'(in_p >> C_SHIFT);
        // The widened multiply keeps the 24th bit: q*MU reaches ~9.9e6.
        w_qh  = qh_t'(w_quo) * C_MU_QH;
        w_t   = t_t'(w_qh >> C_SHIFT);

        s2_valid_d = s2_valid_q;
        s2_p_d     = s2_p_q;
        s2_t_d     = s2_t_q;
        s2_err_d   = s2_err_q;
        if (en) begin
            s2_valid_d = in_valid;
            if (in_valid) begin
                s2_p_d   = in_p;
                s2_t_d   = w_t;
                s2_err_d = in_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: remainder and final correction.
    // The estimate t never exceeds p/Q, so r is non-negative, but the two
    // truncating shifts plus the floored MU let t fall short by up to two
    // (e.g. p = 32*253 gives r = 5673 > 2Q). The correction therefore
    // selects among r, r-Q and r-2Q in a single step.
    // ------------------------------------------------------------------
    always_comb begin
        w_r      = s2_p_q - (prod_t'(s2_t_q) * C_Q_P);
        w_r_sub1 = operand_t'(w_r - C_Q_P);
        w_r_sub2 = operand_t'(w_r - C_Q2_P);

        if (w_r >= C_Q2_P) begin
            w_res = w_r_sub2;
        end else if (w_r >= C_Q_P) begin
            w_res = w_r_sub1;
        end else begin
            w_res = operand_t'(w_r);
        end

        s3_valid_d = s3_valid_q;
        s3_r_d     = s3_r_q;
        s3_err_d   = s3_err_q;
        if (en) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_r_d   = w_res;
                s3_err_d = s2_err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_p_q     <= '0;
            s2_t_q     <= '0;
            s2_err_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_r_q     <= '0;
            s3_err_q   <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_p_q     <= s2_p_d;
            s2_t_q     <= s2_t_d;
            s2_err_q   <= s2_err_d;
            s3_valid_q <= s3_valid_d;
            s3_r_q     <= s3_r_d;
            s3_err_q   <= s3_err_d;
        end
    end

    always_comb begin
        out_valid = s3_valid_q;
        out_r     = s3_r_q;
        out_err   = s3_err_q;
    end

endmodule : barrett_stage_2423
`default_nettype wire

// File: rtl/modmul_pipe_2423.sv
`default_nettype none
// ============================================================================
// Module      : modmul_pipe_2423
// Description : Three-stage pipelined modular multiplier computing
//               (in_a * in_b) mod Q with Barrett reduction and a
//               valid/ready handshake on both sides. A single enable
//               (en = !out_valid | out_ready) advances every stage, so a
//               stalled output freezes the whole pipe without loss.
//               S1 (here) registers the 23-bit product; S2/S3 live in
//               barrett_stage_2423.
// Config      : MODMUL2423_RANGE_CHECK_EN - when defined, out_err flags
//               operands outside 0..Q-1; otherwise out_err is tied low.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               in_valid  - operand pair offered
//               in_ready  - operand pair accepted when in_valid & in_ready
//               in_a/in_b - 12-bit operands, legal range 0..Q-1
//               out_valid - result present
//               out_ready - result consumed when out_valid & out_ready
//               out_r     - 12-bit result
//               out_err   - operand-range flag, qualified by out_valid
// Revision    : 1.0 - initial release
// ============================================================================
module modmul_pipe_2423
    import modq_pkg::*;
#(
    parameter int unsigned Q  = C_Q_DEFAULT,
    parameter int unsigned MU = C_MU_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [C_OP_W-1:0] in_a,
    input  logic [C_OP_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [C_OP_W-1:0] out_r,
    output logic              out_err
);

`ifdef MODMUL2423_RANGE_CHECK_EN
    localparam operand_t C_Q_OP = operand_t'(Q);
`endif

    logic  w_en;
    prod_t w_prod;
    logic  w_err;

    // S1 registers
    logic  s1_valid_q, s1_valid_d;
    prod_t s1_p_q,     s1_p_d;
    logic  s1_err_q,   s1_err_d;

    // ------------------------------------------------------------------
    // Enable and S1: full-width product, optional range flag
    // ------------------------------------------------------------------
    always_comb begin
        w_en   = !out_valid || out_ready;
        // Both operands widened before the multiply so no product bit is lost.
        w_prod = prod_t'(in_a) * prod_t'(in_b);
`ifdef MODMUL2423_RANGE_CHECK_EN
        w_err  = (in_a >= C_Q_OP) || (in_b >= C_Q_OP);
`else
        w_err  = 1'b0;
`endif

        s1_valid_d = s1_valid_q;
        s1_p_d     = s1_p_q;
        s1_err_d   = s1_err_q;
        if (w_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_p_d   = w_prod;
                s1_err_d = w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_p_q     <= s1_p_d;
            s1_err_q   <= s1_err_d;
        end
    end

    assign in_ready = w_en;

    // ------------------------------------------------------------------
    // S2/S3 reduction
    // ------------------------------------------------------------------
    barrett_stage_2423 #(
        .Q  (Q),
        .MU (MU)
    ) u_barrett (
        .clk       (clk),
        .rst       (rst),
        .en        (w_en),
        .in_valid  (s1_valid_q),
        .in_p      (s1_p_q),
        .in_err    (s1_err_q),
        .out_valid (out_valid),
        .out_r     (out_r),
        .out_err   (out_err)
    );

endmodule : modmul_pipe_2423
`default_nettype wire

// File: tb/tb_modmul_pipe_2423.sv
`default_nettype none
// ============================================================================
// Module      : tb_modmul_pipe_2423
// Description : Self-checking bench for modmul_pipe_2423: directed vectors
//               with hand-computed results, a stalled 10-beat stream, a
//               mid-flight reset and a strided/random sweep against a
//               behavioural a*b mod 2423 model.
// Config      : MODMUL2423_RANGE_CHECK_EN selects the expected out_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modmul_pipe_2423;

    localparam int Q_MOD = 2423;
`ifdef MODMUL2423_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_a;
    logic [11:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_r;
    logic        out_err;

    int n_tests;
    int n_fail;

    logic [11:0] qa[$];
    logic [11:0] qb[$];

    modmul_pipe_2423 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operand pair through an empty pipe; result must appear exactly
    // three edges after acceptance.
    task automatic single(input string tag, input int a, input int b, input int exp_r, input bit exp_e);
        in_valid  = 1'b1;
        in_a      = 12'(a);
        in_b      = 12'(b);
        out_ready = 1'b1;
        #1;
        check_val({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        check_val({tag, "_lat1"}, out_valid, 0);
        step();
        check_val({tag, "_lat2"}, out_valid, 0);
        step();
        check_val({tag, "_valid"}, out_valid, 1);
        check_val({tag, "_r"}, out_r, exp_r);
        check_val({tag, "_err"}, out_err, exp_e);
        step();
        check_val({tag, "_drain"}, out_valid, 0);
    endtask

    // Streams qa/qb back-to-back; out_ready drops for stall_len cycles
    // starting at cycle stall_at. Results compared in order to the model.
    task automatic run_stream(input string tag, input int stall_at, input int stall_len);
        int n;
        int sent;
        int got;
        int cyc;
        int exp_r[$];
        bit exp_e[$];
        n    = qa.size();
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < n && cyc < 2 * n + 60) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            in_valid  = (sent < n);
            if (sent < n) begin
                in_a = qa[sent];
                in_b = qb[sent];
            end
            #1;
            if (!out_ready) begin
                check_val({tag, "_stall_in_ready"}, in_ready, 0);
                check_val({tag, "_stall_valid"}, out_valid, 1);
                if (exp_r.size() > 0)
                    check_val({tag, "_stall_hold"}, out_r, exp_r[0]);
            end
            if (out_valid && out_ready) begin
                if (exp_r.size() == 0) begin
                    check_val({tag, "_extra_result"}, 1, 0);
                end else begin
                    check_val({tag, "_r"}, out_r, exp_r[0]);
                    check_val({tag, "_err"}, out_err, exp_e[0]);
                    void'(exp_r.pop_front());
                    void'(exp_e.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_r.push_back((int'(qa[sent]) * int'(qb[sent])) % Q_MOD);
                exp_e.push_back(RC && (int'(qa[sent]) >= Q_MOD || int'(qb[sent]) >= Q_MOD));
                sent++;
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val({tag, "_count"}, got, n);
        repeat (4) step();
        check_val({tag, "_no_dup"}, out_valid, 0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) step();
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_r", out_r, 0);
        check_val("rst_out_err", out_err, 0);
        check_val("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        step();
        check_val("post_rst_in_ready", in_ready, 1);

        // Directed vectors
        single("sq_max",   2422, 2422,    1, 1'b0);  // p=5866084, r=2424 -> 1
        single("a1000_b3", 1000,    3,  577, 1'b0);  // 3000-2423
        single("a1234_b2", 1234,    2,   45, 1'b0);  // 2468-2423
        single("a0",          0, 2422,    0, 1'b0);
        single("two_corr",   32,  253,  827, 1'b0);  // 8096-3*2423
        single("oor_a",    2423,    1,    0, RC);
        single("edge_a",   2422,    1, 2422, 1'b0);

        // 10-beat stream with a 4-cycle output stall
        begin
            int ta[10] = '{5, 2422, 1000, 1234, 0, 32, 17, 2000, 1500, 77};
            int tb[10] = '{7, 2422, 3, 2, 9, 253, 2400, 1999, 1600, 88};
            for (int i = 0; i < 10; i++) begin
                qa.push_back(12'(ta[i]));
                qb.push_back(12'(tb[i]));
            end
        end
        run_stream("strm", 5, 4);

        // Reset with three items in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 12'(100 + i);
            in_b     = 12'(200 + i);
            step();
        end
        in_valid = 1'b0;
        check_val("flight_full", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_mid_valid", out_valid, 0);
        check_val("rst_mid_r", out_r, 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 12'd1000;
        in_b      = 12'd3;
        #1;
        check_val("rst_mid_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 3) begin
                check_val("rst_new_valid", out_valid, 1);
                check_val("rst_new_r", out_r, 577);
            end else begin
                check_val("rst_no_stale", out_valid, 0);
            end
            step();
        end

        // Strided sweep plus random pairs against the model
        for (int a = 0; a <= 2422; a += 97) begin
            for (int b = 0; b <= 2422; b += 97) begin
                qa.push_back(12'(a));
                qb.push_back(12'(b));
            end
            qa.push_back(12'(a));
            qb.push_back(12'd2422);
        end
        for (int i = 0; i < 400; i++) begin
            qa.push_back(12'($urandom_range(0, 2422)));
            qb.push_back(12'($urandom_range(0, 2422)));
        end
        run_stream("sweep", 1 << 30, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_modmul_pipe_2423
`default_nettype wire
